// File: rtl/vx_fpu_shared_arbiter.sv
// Round-robin arbiter sharing one FPU unit among NUM_REQS requesters.
// Tracks op ownership in a FIFO and accumulates sticky fflags per requester.
module vx_fpu_shared_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 3,
    parameter int TAG_W       = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        req_valid,
    output logic [NUM_REQS-1:0]        req_ready,
    input  logic [NUM_REQS*OP_W-1:0]   req_op,
    input  logic [NUM_REQS*3-1:0]      req_frm,
    input  logic [NUM_REQS*DATA_W-1:0] req_dataa,
    input  logic [NUM_REQS*DATA_W-1:0] req_datab,
    input  logic [NUM_REQS*TAG_W-1:0]  req_tag,
    output logic                       unit_req_valid,
    input  logic                       unit_req_ready,
    output logic [OP_W-1:0]            unit_req_op,
    output logic [2:0]                 unit_req_frm,
    output logic [DATA_W-1:0]          unit_req_dataa,
    output logic [DATA_W-1:0]          unit_req_datab,
    output logic [TAG_W-1:0]           unit_req_tag,
    input  logic                       unit_rsp_valid,
    output logic                       unit_rsp_ready,
    input  logic [DATA_W-1:0]          unit_rsp_result,
    input  logic [4:0]                 unit_rsp_fflags,
    input  logic [TAG_W-1:0]           unit_rsp_tag,
    output logic [NUM_REQS-1:0]        rsp_valid,
    input  logic [NUM_REQS-1:0]        rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic [4:0]                 rsp_fflags,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [NUM_REQS*5-1:0]      fflags_acc,
    input  logic [NUM_REQS-1:0]        fflags_clr
);

    localparam int IDX_W = $clog2(NUM_REQS);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      own_q [MAX_PENDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      pending;
    logic [NUM_REQS*5-1:0] acc_q;
    logic [NUM_REQS*5-1:0] acc_next;

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] head;
    logic             empty;
    logic             can_issue;
    logic             issue_fire;
    logic             rsp_fire;

    assign head       = own_q[rd_ptr];
    assign empty      = (pending == '0);
    assign rsp_fire   = unit_rsp_valid && unit_rsp_ready;
    assign can_issue  = (pending < CNT_W'(MAX_PENDING)) || rsp_fire;
    assign issue_fire = unit_req_valid && unit_req_ready;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        int j;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            j = int'(last_grant) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (!found && req_valid[IDX_W'(j)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Issue-side handshake and payload mux, all forced idle in reset
    always_comb begin
        req_ready      = '0;
        unit_req_valid = !reset && (|req_valid) && can_issue;
        if (!reset && (|req_valid) && can_issue && unit_req_ready)
            req_ready[grant_idx] = 1'b1;
    end

    assign unit_req_op    = req_op[grant_idx*OP_W +: OP_W];
    assign unit_req_frm   = req_frm[grant_idx*3 +: 3];
    assign unit_req_dataa = req_dataa[grant_idx*DATA_W +: DATA_W];
    assign unit_req_datab = req_datab[grant_idx*DATA_W +: DATA_W];
    assign unit_req_tag   = req_tag[grant_idx*TAG_W +: TAG_W];

    // Route the unit response to the owner at the FIFO head
    always_comb begin
        rsp_valid      = '0;
        unit_rsp_ready = !reset && !empty && rsp_ready[head];
        if (!reset && unit_rsp_valid)
            rsp_valid[head] = 1'b1;
    end

    assign rsp_result = unit_rsp_result;
    assign rsp_fflags = unit_rsp_fflags;
    assign rsp_tag    = unit_rsp_tag;

    // Sticky flag update; a clear drops old flags but keeps new ones
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (fflags_clr[i])
                acc_next[i*5 +: 5] = 5'b0;
            if (rsp_fire && head == IDX_W'(i))
                acc_next[i*5 +: 5] = acc_next[i*5 +: 5] | unit_rsp_fflags;
        end
    end

    assign fflags_acc = acc_q;

    // Pointers, occupancy, round-robin state and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_REQS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= '0;
            acc_q      <= '0;
        end else begin
            acc_q <= acc_next;
            if (issue_fire) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant_idx;
            end
            if (rsp_fire)
                rd_ptr <= rd_ptr + 1'b1;
            if (issue_fire && !rsp_fire)
                pending <= pending + 1'b1;
            else if (!issue_fire && rsp_fire)
                pending <= pending - 1'b1;
        end
    end

    // Ownership storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (!reset && issue_fire)
            own_q[wr_ptr] <= grant_idx;
    end

`ifndef SYNTHESIS
    a_rsp_without_owner: assert property (
        @(posedge clk) disable iff (reset) !(unit_rsp_valid && empty)
    );
`endif

endmodule

// File: tb/tb_vx_fpu_shared_arbiter.sv
// Directed scoreboard bench for vx_fpu_shared_arbiter.
// Expected issues/responses are queued by stimulus, popped by the monitor.
module tb_vx_fpu_shared_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*3-1:0]  req_op;
    logic [N*3-1:0]  req_frm;
    logic [N*32-1:0] req_dataa;
    logic [N*32-1:0] req_datab;
    logic [N*8-1:0]  req_tag;
    logic          unit_req_valid;
    logic          unit_req_ready;
    logic [2:0]    unit_req_op;
    logic [2:0]    unit_req_frm;
    logic [31:0]   unit_req_dataa;
    logic [31:0]   unit_req_datab;
    logic [7:0]    unit_req_tag;
    logic          unit_rsp_valid;
    logic          unit_rsp_ready;
    logic [31:0]   unit_rsp_result;
    logic [4:0]    unit_rsp_fflags;
    logic [7:0]    unit_rsp_tag;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [31:0]   rsp_result;
    logic [4:0]    rsp_fflags;
    logic [7:0]    rsp_tag;
    logic [N*5-1:0] fflags_acc;
    logic [N-1:0]  fflags_clr;

    vx_fpu_shared_arbiter #(
        .NUM_REQS(4), .DATA_W(32), .OP_W(3), .TAG_W(8), .MAX_PENDING(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_frm(req_frm),
        .req_dataa(req_dataa), .req_datab(req_datab), .req_tag(req_tag),
        .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
        .unit_req_op(unit_req_op), .unit_req_frm(unit_req_frm),
        .unit_req_dataa(unit_req_dataa), .unit_req_datab(unit_req_datab),
        .unit_req_tag(unit_req_tag),
        .unit_rsp_valid(unit_rsp_valid), .unit_rsp_ready(unit_rsp_ready),
        .unit_rsp_result(unit_rsp_result), .unit_rsp_fflags(unit_rsp_fflags),
        .unit_rsp_tag(unit_rsp_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_fflags(rsp_fflags), .rsp_tag(rsp_tag),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vec;
        logic [31:0] res;
        logic [4:0]  ff;
    } rsp_t;

    int   exp_iss [$];
    rsp_t exp_rsp [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_iss(input int idx);
        exp_iss.push_back(idx);
    endtask

    task automatic drive_rsp(input logic [3:0] vec, input logic [31:0] res,
                             input logic [4:0] ff);
        rsp_t e;
        unit_rsp_valid  = 1'b1;
        unit_rsp_result = res;
        unit_rsp_fflags = ff;
        unit_rsp_tag    = res[7:0];
        e.vec = vec;
        e.res = res;
        e.ff  = ff;
        exp_rsp.push_back(e);
    endtask

    task automatic do_reset();
        req_valid      = '0;
        unit_rsp_valid = 1'b0;
        fflags_clr     = '0;
        reset          = 1'b1;
        tick();
        reset          = 1'b0;
    endtask

    // Monitor: pop and compare whenever a handshake appears on either side
    always @(negedge clk) begin
        if (!reset && unit_req_valid && unit_req_ready) begin
            if (exp_iss.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got req_ready %b expected none",
                         req_ready);
            end else begin
                int g;
                g = exp_iss.pop_front();
                chk("iss_ready", 64'(req_ready), 64'(4'b0001 << g));
                chk("iss_op",    64'(unit_req_op), 64'(g + 1));
                chk("iss_dataa", 64'(unit_req_dataa), 64'(32'hA000_0000 + g));
                chk("iss_tag",   64'(unit_req_tag), 64'(8'h10 + g));
            end
        end
        if (!reset && unit_rsp_valid && unit_rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid %b expected none",
                         rsp_valid);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_vec",    64'(rsp_valid), 64'(e.vec));
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_fflags", 64'(rsp_fflags), 64'(e.ff));
                chk("rsp_tag",    64'(rsp_tag), 64'(e.res[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_op[i*3 +: 3]     = 3'(i + 1);
            req_frm[i*3 +: 3]    = 3'(i);
            req_dataa[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            req_datab[i*32 +: 32] = 32'hB000_0000 + 32'(i);
            req_tag[i*8 +: 8]    = 8'h10 + 8'(i);
        end
        reset           = 1'b1;
        req_valid       = '0;
        unit_req_ready  = 1'b0;
        unit_rsp_valid  = 1'b0;
        unit_rsp_result = '0;
        unit_rsp_fflags = '0;
        unit_rsp_tag    = '0;
        rsp_ready       = '0;
        fflags_clr      = '0;
        tick();

        // Outputs idle in reset even with every input active
        req_valid      = 4'hF;
        unit_req_ready = 1'b1;
        unit_rsp_valid = 1'b1;
        rsp_ready      = 4'hF;
        @(negedge clk);
        chk("rst_unit_req_valid", 64'(unit_req_valid), 64'(0));
        chk("rst_req_ready",      64'(req_ready), 64'(0));
        chk("rst_rsp_valid",      64'(rsp_valid), 64'(0));
        chk("rst_unit_rsp_ready", 64'(unit_rsp_ready), 64'(0));
        chk("rst_fflags_acc",     64'(fflags_acc), 64'(0));
        tick();
        do_reset();

        // Requester 2 alone
        req_valid = 4'b0100;
        push_iss(2);
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'(4'b0100));
        chk("t1_datab",     64'(unit_req_datab), 64'(32'hB000_0002));
        chk("t1_frm",       64'(unit_req_frm), 64'(2));
        tick();
        req_valid = '0;
        drive_rsp(4'b0100, 32'hCAFE_0002, 5'b01000);
        @(negedge clk);
        chk("t1_unit_rsp_ready", 64'(unit_rsp_ready), 64'(1));
        tick();
        unit_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t1_acc2", 64'(fflags_acc[14:10]), 64'(5'b01000));
        tick();

        // All valid: 0,1,2,3 then stall at full occupancy
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push_iss(k);
            tick();
        end
        @(negedge clk);
        chk("t2_full_valid", 64'(unit_req_valid), 64'(0));
        chk("t2_full_ready", 64'(req_ready), 64'(0));
        tick();

        // Full: response and new issue in the same cycle
        drive_rsp(4'b0001, 32'h1111_0000, 5'b00000);
        push_iss(0);
        @(negedge clk);
        chk("t3_rsp_ready", 64'(unit_rsp_ready), 64'(1));
        chk("t3_req_valid", 64'(unit_req_valid), 64'(1));
        tick();
        unit_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t3_still_full", 64'(unit_req_valid), 64'(0));
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            drive_rsp(4'(4'b0001 << ((k + 1) % 4)),
                      32'h2222_0000 + 32'(k), 5'b00000);
            tick();
        end
        unit_rsp_valid = 1'b0;

        // Issues by 1,3,1 and in-order routing with backpressure
        req_valid = 4'b0010;
        push_iss(1);
        tick();
        req_valid = 4'b1000;
        push_iss(3);
        tick();
        req_valid = 4'b0010;
        push_iss(1);
        tick();
        req_valid = '0;
        drive_rsp(4'b0010, 32'h3333_0001, 5'b00001);
        tick();
        unit_rsp_valid  = 1'b1;
        unit_rsp_result = 32'h3333_0003;
        unit_rsp_fflags = 5'b00000;
        rsp_ready       = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_hold_vec",   64'(rsp_valid), 64'(4'b1000));
            chk("t4_hold_ready", 64'(unit_rsp_ready), 64'(0));
            tick();
        end
        rsp_ready = 4'hF;
        drive_rsp(4'b1000, 32'h3333_0003, 5'b00000);
        tick();
        drive_rsp(4'b0010, 32'h3333_0011, 5'b10000);
        tick();
        unit_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t5_acc1", 64'(fflags_acc[9:5]), 64'(5'b10001));
        chk("t5_acc3", 64'(fflags_acc[19:15]), 64'(5'b00000));
        tick();

        // Clear concurrent with a new flag update keeps only the new flags
        req_valid = 4'b0010;
        push_iss(1);
        tick();
        req_valid = '0;
        drive_rsp(4'b0010, 32'h4444_0001, 5'b00100);
        fflags_clr = 4'b0010;
        tick();
        unit_rsp_valid = 1'b0;
        fflags_clr     = '0;
        @(negedge clk);
        chk("t5_clr_acc1", 64'(fflags_acc[9:5]), 64'(5'b00100));
        tick();

        // Reset with three ops pending
        req_valid = 4'hF;
        push_iss(2);
        tick();
        push_iss(3);
        tick();
        push_iss(0);
        tick();
        do_reset();
        rsp_ready = 4'hF;
        @(negedge clk);
        chk("t6_rsp_valid",      64'(rsp_valid), 64'(0));
        chk("t6_unit_rsp_ready", 64'(unit_rsp_ready), 64'(0));
        chk("t6_fflags_acc",     64'(fflags_acc), 64'(0));
        tick();
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push_iss(k);
            tick();
        end
        @(negedge clk);
        chk("t6_full_after_4", 64'(unit_req_valid), 64'(0));
        tick();
        do_reset();

        chk("iss_queue_drained", 64'(exp_iss.size()), 64'(0));
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
